// File: rtl/noc_cfg_pkg.sv
// Shared types for the NoC configuration sequencer: word/id widths, the
// dispatcher state enum and the queued request layout.
package noc_cfg_pkg;

  localparam int CFG_W  = 11;
  localparam int N_PROC = 4;
  localparam int PID_W  = 2;
  localparam int REQ_W  = PID_W + CFG_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [PID_W-1:0] dest;
    logic [CFG_W-1:0] cfg;
  } req_t;

endpackage

// File: rtl/noc_cfg_fifo.sv
// Small synchronous request FIFO; pointers wrap modulo DEPTH and a separate
// occupancy count distinguishes full from empty.
module noc_cfg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push_en;
  logic          w_pop_en;

  assign full      = (r_cnt == FULL_CNT);
  assign empty     = (r_cnt == '0);
  assign head      = r_mem[r_rd];
  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_en) r_wr <= r_wr + 1'b1;
      if (w_pop_en)  r_rd <= r_rd + 1'b1;
      case ({w_push_en, w_pop_en})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is never observed while empty, so it needs no reset.
  always_ff @(posedge clock) begin
    if (w_push_en) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/noc_config_sequencer.sv
// Queues host configuration requests and delivers each word to its target
// mesh processor once that processor reports ready, one delivery at a time.
module noc_config_sequencer
  import noc_cfg_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PID_W-1:0]  req_dest,
  input  logic [CFG_W-1:0]  req_cfg,
  input  logic [N_PROC-1:0] processor_ready_signals,
  output logic [CFG_W-1:0]  p0_configure,
  output logic [CFG_W-1:0]  p1_configure,
  output logic [CFG_W-1:0]  p2_configure,
  output logic [CFG_W-1:0]  p3_configure,
  output logic [N_PROC-1:0] cfg_strobe,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int HLD_W = $clog2(HOLD_CYCLES + 1);

  state_e            r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [HLD_W-1:0]  r_hold;
  logic [N_PROC-1:0] r_strobe;
  logic [7:0]        r_err;
  logic [CFG_W-1:0]  r_cfg [N_PROC];
  req_t              r_cur;

  req_t              w_din;
  req_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

  assign w_din     = '{dest: req_dest, cfg: req_cfg};
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign req_ready = !w_full;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

  assign p0_configure = r_cfg[0];
  assign p1_configure = r_cfg[1];
  assign p2_configure = r_cfg[2];
  assign p3_configure = r_cfg[3];
  assign cfg_strobe   = r_strobe;
  assign err_count    = r_err;

  noc_cfg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req_valid),
    .pop   (w_pop),
    .din   (w_din),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  always_ff @(posedge clock) begin
    if (w_pop) r_cur <= w_head;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_hold   <= '0;
      r_strobe <= '0;
      r_err    <= '0;
      for (int i = 0; i < N_PROC; i++) r_cfg[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_timer <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (processor_ready_signals[r_cur.dest]) begin
            r_cfg[r_cur.dest] <= r_cur.cfg;
            r_strobe          <= N_PROC'(1) << r_cur.dest;
            r_state           <= ST_DRIVE;
          end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
            // Target never became ready: drop the request, outputs untouched.
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DRIVE: begin
          r_strobe <= '0;
          r_hold   <= '0;
          r_state  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_hold == HLD_W'(HOLD_CYCLES - 1)) r_state <= ST_IDLE;
          else                                   r_hold  <= r_hold + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_config_sequencer.sv
// Scoreboard bench: stimulus predicts each request's fate from the readiness
// mask it applies; a monitor checks every strobe and the sticky outputs.
module tb_noc_config_sequencer;
  import noc_cfg_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [PID_W-1:0]  req_dest = '0;
  logic [CFG_W-1:0]  req_cfg = '0;
  logic [N_PROC-1:0] processor_ready_signals = '0;
  logic [CFG_W-1:0]  p0_configure, p1_configure, p2_configure, p3_configure;
  logic [N_PROC-1:0] cfg_strobe;
  logic              busy;
  logic [7:0]        err_count;

  noc_config_sequencer dut (
    .clock                   (clock),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_dest                (req_dest),
    .req_cfg                 (req_cfg),
    .processor_ready_signals (processor_ready_signals),
    .p0_configure            (p0_configure),
    .p1_configure            (p1_configure),
    .p2_configure            (p2_configure),
    .p3_configure            (p3_configure),
    .cfg_strobe              (cfg_strobe),
    .busy                    (busy),
    .err_count               (err_count)
  );

  always #5 clock = ~clock;

  typedef struct { int dest; int cfg; } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int mdl_cfg [4];
  int mdl_err = 0;
  logic [3:0] mdl_mask = 4'h0;
  int last_strobe_cyc = -1000;
  int last_gap = 0;
  int n_strobes = 0;
  int push_cyc = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: every strobe consumes one predicted delivery.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) mdl_cfg[i] = 0;
      last_strobe_cyc = -1000;
    end else begin
      if (cfg_strobe != '0) begin
        n_strobes++;
        last_gap = cyc - last_strobe_cyc;
        check("strobe_spacing_at_least_6", int'(last_gap >= 6), 1);
        last_strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", int'(cfg_strobe), 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("strobe_onehot", int'(cfg_strobe), 1 << e_mon.dest);
          mdl_cfg[e_mon.dest] = e_mon.cfg;
        end
      end
      check("p0_configure", int'(p0_configure), mdl_cfg[0]);
      check("p1_configure", int'(p1_configure), mdl_cfg[1]);
      check("p2_configure", int'(p2_configure), mdl_cfg[2]);
      check("p3_configure", int'(p3_configure), mdl_cfg[3]);
    end
  end

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic push(input int d, input int c);
    int w;
    req_dest  = PID_W'(d);
    req_cfg   = CFG_W'(c);
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 500) begin
      @(negedge clock);
      w++;
    end
    if (!req_ready) begin
      check("push_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    push_cyc = cyc + 1;
    if (mdl_mask[d]) exp_q.push_back('{d, c});
    else             mdl_err = (mdl_err < 255) ? mdl_err + 1 : 255;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while (busy && w < budget) begin
      @(negedge clock);
      w++;
    end
    check("idle_within_budget", int'(busy), 0);
    check("all_predicted_delivered", exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int p;
    int s0;

    // Reset held with a request presented: nothing may be queued.
    req_valid = 1'b1;
    repeat (17) @(negedge clock);
    check("rst_p0", int'(p0_configure), 0);
    check("rst_p3", int'(p3_configure), 0);
    check("rst_strobe", int'(cfg_strobe), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_req_ready", int'(req_ready), 1);
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("post_rst_no_strobe", n_strobes, 0);
    check("post_rst_busy", int'(busy), 0);

    // Single delivery with all processors ready.
    mdl_mask = 4'hF;
    processor_ready_signals = 4'hF;
    push(0, 11'h205);
    p = push_cyc;
    wait_idle(50);
    check("t2_latency", last_strobe_cyc - p, 2);
    check("t2_busy_low_after_hold", cyc - last_strobe_cyc, 4);
    check("t2_p0", int'(p0_configure), 11'h205);

    // Back-to-back requests: exact minimum spacing.
    push(0, 11'h203);
    push(3, 11'h201);
    wait_idle(50);
    check("t3_gap", last_gap, 6);
    check("t3_p0_kept", int'(p0_configure), 11'h203);
    check("t3_p3", int'(p3_configure), 11'h201);

    // Timeout on an unready processor, then the next request is served.
    mdl_mask = 4'b1011;
    processor_ready_signals = 4'b1011;
    push(2, 11'h7FF);
    p = push_cyc;
    push(1, 11'h111);
    wait_idle(300);
    check("t4_err", int'(err_count), 1);
    check("t4_p2_untouched", int'(p2_configure), 0);
    check("t4_next_served_time", last_strobe_cyc - p, 67);

    // Fill the queue while nobody is ready, then release.
    mdl_mask = 4'hF;
    processor_ready_signals = 4'h0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("t5_ready_before_5th", int'(req_ready), 1);
      push(i % 4, $urandom_range(0, 2047));
    end
    check("t5_full", int'(req_ready), 0);
    processor_ready_signals = 4'hF;
    wait_idle(200);
    check("t5_err_unchanged", int'(err_count), mdl_err);

    // Reset during HOLD with two entries still queued.
    push(1, 11'h0AA);
    push(2, 11'h155);
    push(3, 11'h3C3);
    s0 = n_strobes;
    for (int w = 0; w < 20 && n_strobes == s0; w++) @(negedge clock);
    check("t6_first_strobe", n_strobes - s0, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("t6_p1_cleared", int'(p1_configure), 0);
    check("t6_strobe", int'(cfg_strobe), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_req_ready", int'(req_ready), 1);
    mdl_err = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    s0 = n_strobes;
    repeat (30) @(negedge clock);
    check("t6_no_strobe_after", n_strobes - s0, 0);
    check("t6_busy_after", int'(busy), 0);
    check("t6_err_after", int'(err_count), 0);

    // Randomized rounds with a fixed readiness mask per round.
    for (int r = 0; r < 8; r++) begin
      mdl_mask = 4'($urandom_range(0, 15));
      processor_ready_signals = mdl_mask;
      for (int k = 0; k < 6; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
        push($urandom_range(0, 3), $urandom_range(0, 2047));
      end
      wait_idle(1000);
      check("rand_err_count", int'(err_count), mdl_err);
    end

    // Error counter saturation.
    mdl_mask = 4'h0;
    processor_ready_signals = 4'h0;
    for (int k = 0; k < 258; k++) push($urandom_range(0, 3), $urandom_range(0, 2047));
    wait_idle(1000);
    check("err_saturated", int'(err_count), 255);
    check("err_model", int'(err_count), mdl_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
